// File: rtl/dcache_mshr_if.sv
// LSQ request, memory bus, cache fill and completion signals of the miss-handling stage.
// The master side is the LSQ/memory/cache environment; the slave side is dcache_mshr.
interface dcache_mshr_if #(parameter int ID_W = 5);
  logic            req_valid;
  logic            req_is_store;
  logic [63:0]     req_addr;
  logic [63:0]     req_data;
  logic [ID_W-1:0] req_id;
  logic            req_ready;

  logic [1:0]      proc2mem_command;
  logic [63:0]     proc2mem_addr;
  logic [63:0]     proc2mem_data;
  logic [3:0]      mem2proc_response;
  logic [63:0]     mem2proc_data;
  logic [3:0]      mem2proc_tag;

  logic            wr_mem_en;
  logic [3:0]      wr_mem_idx;
  logic [8:0]      wr_mem_tag;
  logic [63:0]     wr_mem_data;

  logic            ld_done_valid;
  logic [ID_W-1:0] ld_done_id;
  logic [63:0]     ld_done_data;
  logic            st_done_valid;
  logic [ID_W-1:0] st_done_id;

  modport master (
    output req_valid, req_is_store, req_addr, req_data, req_id,
           mem2proc_response, mem2proc_data, mem2proc_tag,
    input  req_ready, proc2mem_command, proc2mem_addr, proc2mem_data,
           wr_mem_en, wr_mem_idx, wr_mem_tag, wr_mem_data,
           ld_done_valid, ld_done_id, ld_done_data, st_done_valid, st_done_id
  );

  modport slave (
    input  req_valid, req_is_store, req_addr, req_data, req_id,
           mem2proc_response, mem2proc_data, mem2proc_tag,
    output req_ready, proc2mem_command, proc2mem_addr, proc2mem_data,
           wr_mem_en, wr_mem_idx, wr_mem_tag, wr_mem_data,
           ld_done_valid, ld_done_id, ld_done_data, st_done_valid, st_done_id
  );
endinterface

// File: rtl/dcache_mshr.sv
// In-order miss/store issue to memory with out-of-order load returns; command one cycle after accept,
// completions one cycle after memory accept/return. LSQ is stalled while the next circular slot is busy.
module dcache_mshr #(
  parameter int N_ENTRIES = 4,
  parameter int ID_W      = 5
) (
  input logic           clock,
  input logic           reset,
  dcache_mshr_if.slave  bus
);
  localparam int PW = $clog2(N_ENTRIES);
  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;

  typedef enum logic [1:0] {EMPTY = 2'd0, WAIT_ISSUE = 2'd1, WAIT_DATA = 2'd2} state_t;

  state_t          state    [N_ENTRIES];
  logic            is_store [N_ENTRIES];
  logic [63:0]     addr     [N_ENTRIES];
  logic [63:0]     data     [N_ENTRIES];
  logic [ID_W-1:0] id       [N_ENTRIES];
  logic [3:0]      mem_tag  [N_ENTRIES];

  logic [PW-1:0]   alloc_ptr;
  logic [PW-1:0]   issue_ptr;
  logic            issue_vld;
  logic            issue_fire;
  logic            ret_hit;
  logic [PW-1:0]   ret_idx;

  logic            wr_mem_en_q;
  logic [3:0]      wr_mem_idx_q;
  logic [8:0]      wr_mem_tag_q;
  logic [63:0]     wr_mem_data_q;
  logic            ld_done_valid_q;
  logic [ID_W-1:0] ld_done_id_q;
  logic            st_done_valid_q;
  logic [ID_W-1:0] st_done_id_q;

  // Memory never reuses a live tag, so at most one entry can match.
  always_comb begin
    ret_hit = 1'b0;
    ret_idx = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (state[i] == WAIT_DATA && bus.mem2proc_tag != 4'd0 && mem_tag[i] == bus.mem2proc_tag) begin
        ret_hit = 1'b1;
        ret_idx = PW'(i);
      end
    end
  end

  assign bus.req_ready        = (state[alloc_ptr] == EMPTY);
  assign issue_vld            = (state[issue_ptr] == WAIT_ISSUE);
  assign issue_fire           = issue_vld && (bus.mem2proc_response != 4'd0);
  assign bus.proc2mem_command = issue_vld ? (is_store[issue_ptr] ? CMD_STORE : CMD_LOAD) : CMD_NONE;
  assign bus.proc2mem_addr    = issue_vld ? (addr[issue_ptr] & ~64'h7) : 64'd0;
  assign bus.proc2mem_data    = issue_vld ? data[issue_ptr] : 64'd0;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_ENTRIES; i++) state[i] <= EMPTY;
      alloc_ptr       <= '0;
      issue_ptr       <= '0;
      wr_mem_en_q     <= 1'b0;
      wr_mem_idx_q    <= '0;
      wr_mem_tag_q    <= '0;
      wr_mem_data_q   <= '0;
      ld_done_valid_q <= 1'b0;
      ld_done_id_q    <= '0;
      st_done_valid_q <= 1'b0;
      st_done_id_q    <= '0;
    end else begin
      wr_mem_en_q     <= 1'b0;
      ld_done_valid_q <= 1'b0;
      st_done_valid_q <= 1'b0;

      if (bus.req_valid && bus.req_ready) begin
        state[alloc_ptr]    <= WAIT_ISSUE;
        is_store[alloc_ptr] <= bus.req_is_store;
        addr[alloc_ptr]     <= bus.req_addr;
        data[alloc_ptr]     <= bus.req_data;
        id[alloc_ptr]       <= bus.req_id;
        alloc_ptr           <= alloc_ptr + 1'b1;
      end

      // Stores retire as soon as memory accepts them; loads wait for their tag.
      if (issue_fire) begin
        issue_ptr <= issue_ptr + 1'b1;
        if (is_store[issue_ptr]) begin
          state[issue_ptr] <= EMPTY;
          st_done_valid_q  <= 1'b1;
          st_done_id_q     <= id[issue_ptr];
        end else begin
          state[issue_ptr]   <= WAIT_DATA;
          mem_tag[issue_ptr] <= bus.mem2proc_response;
        end
      end

      if (ret_hit) begin
        state[ret_idx]  <= EMPTY;
        wr_mem_en_q     <= 1'b1;
        wr_mem_idx_q    <= addr[ret_idx][6:3];
        wr_mem_tag_q    <= addr[ret_idx][15:7];
        wr_mem_data_q   <= bus.mem2proc_data;
        ld_done_valid_q <= 1'b1;
        ld_done_id_q    <= id[ret_idx];
      end
    end
  end

  assign bus.wr_mem_en     = wr_mem_en_q;
  assign bus.wr_mem_idx    = wr_mem_idx_q;
  assign bus.wr_mem_tag    = wr_mem_tag_q;
  assign bus.wr_mem_data   = wr_mem_data_q;
  assign bus.ld_done_valid = ld_done_valid_q;
  assign bus.ld_done_id    = ld_done_id_q;
  assign bus.ld_done_data  = wr_mem_data_q;
  assign bus.st_done_valid = st_done_valid_q;
  assign bus.st_done_id    = st_done_id_q;
endmodule

// File: tb/tb_dcache_mshr.sv
// Bench for dcache_mshr: directed vector table, hand sequences for full/reset corners,
// then random traffic against a queue-based reference model.
module tb_dcache_mshr;
  localparam int N  = 4;
  localparam int IW = 5;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  dcache_mshr_if #(.ID_W(IW)) bus ();
  dcache_mshr #(.N_ENTRIES(N), .ID_W(IW)) dut (.clock(clock), .reset(reset), .bus(bus));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: requests waiting to issue in program order, loads waiting for data,
  // and occupancy of the circular slots.
  typedef struct {
    int              slot;
    bit              st;
    logic [63:0]     a;
    logic [63:0]     d;
    logic [IW-1:0]   id;
    logic [3:0]      tag;
  } mreq_t;

  mreq_t         iq[$];
  mreq_t         wd[$];
  bit            busy[N];
  int            acnt;
  bit            e_st, e_ld;
  logic [IW-1:0] e_st_id, e_ld_id;
  logic [63:0]   e_ld_data, e_ld_addr;

  function automatic logic [1:0] m_cmd();
    if (iq.size() == 0) return 2'd0;
    return iq[0].st ? 2'd2 : 2'd1;
  endfunction

  function automatic bit tag_live(input int t);
    foreach (wd[k]) if (int'(wd[k].tag) == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_check();
    chk("req_ready", bus.req_ready, !busy[acnt % N]);
    chk("command", bus.proc2mem_command, m_cmd());
    chk("mem_addr", bus.proc2mem_addr, (iq.size() == 0) ? 64'd0 : {iq[0].a[63:3], 3'b000});
    if (m_cmd() == 2'd2) chk("mem_data", bus.proc2mem_data, iq[0].d);
    chk("st_done_valid", bus.st_done_valid, e_st);
    if (e_st) chk("st_done_id", bus.st_done_id, e_st_id);
    chk("ld_done_valid", bus.ld_done_valid, e_ld);
    chk("wr_mem_en", bus.wr_mem_en, e_ld);
    if (e_ld) begin
      chk("ld_done_id", bus.ld_done_id, e_ld_id);
      chk("ld_done_data", bus.ld_done_data, e_ld_data);
      chk("wr_mem_data", bus.wr_mem_data, e_ld_data);
      chk("wr_mem_idx", bus.wr_mem_idx, (e_ld_addr >> 3) % 16);
      chk("wr_mem_tag", bus.wr_mem_tag, (e_ld_addr >> 7) % 512);
    end
  endtask

  task automatic model_step();
    bit    rdy;
    int    hit;
    mreq_t h;
    rdy = !busy[acnt % N];
    if (reset) begin
      iq.delete();
      wd.delete();
      foreach (busy[k]) busy[k] = 1'b0;
      acnt = 0;
      e_st = 0;
      e_ld = 0;
    end else begin
      e_st = 0;
      e_ld = 0;
      hit = -1;
      if (bus.mem2proc_tag != 4'd0)
        for (int k = 0; k < wd.size(); k++) if (wd[k].tag == bus.mem2proc_tag) hit = k;
      if (hit >= 0) begin
        e_ld      = 1;
        e_ld_id   = wd[hit].id;
        e_ld_data = bus.mem2proc_data;
        e_ld_addr = wd[hit].a;
        busy[wd[hit].slot] = 1'b0;
        wd.delete(hit);
      end
      if (iq.size() != 0 && bus.mem2proc_response != 4'd0) begin
        h = iq.pop_front();
        if (h.st) begin
          e_st    = 1;
          e_st_id = h.id;
          busy[h.slot] = 1'b0;
        end else begin
          h.tag = bus.mem2proc_response;
          wd.push_back(h);
        end
      end
      if (bus.req_valid && rdy) begin
        h = '{acnt % N, bus.req_is_store, bus.req_addr, bus.req_data, bus.req_id, 4'd0};
        busy[acnt % N] = 1'b1;
        iq.push_back(h);
        acnt++;
      end
    end
  endtask

  task automatic cycle();
    model_check();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_in();
    bus.req_valid = 0; bus.req_is_store = 0; bus.req_addr = 0; bus.req_data = 0; bus.req_id = 0;
    bus.mem2proc_response = 0; bus.mem2proc_data = 0; bus.mem2proc_tag = 0;
  endtask

  task automatic do_reset();
    clear_in();
    reset = 1;
    cycle();
    reset = 0;
  endtask

  // Directed vectors: inputs applied in a cycle plus the outputs expected in that same cycle.
  typedef struct {
    logic rv, st; logic [63:0] a, d; logic [IW-1:0] id; logic [3:0] rsp, rtag; logic [63:0] rdat;
    logic e_rdy; logic [1:0] e_cmd; logic [63:0] e_addr, e_pd; logic e_st; logic [IW-1:0] e_sid;
    logic e_ld; logic [63:0] e_ldat; logic [IW-1:0] e_lid; logic [3:0] e_idx; logic [8:0] e_tag;
  } vec_t;
  vec_t tbl[$];

  task automatic push(input logic rv, st, input logic [63:0] a, d, input int id,
                      input logic [3:0] rsp, rtag, input logic [63:0] rdat,
                      input logic e_rdy, input logic [1:0] e_cmd, input logic [63:0] e_addr, e_pd,
                      input logic e_st, input int e_sid, input logic e_ld, input logic [63:0] e_ldat,
                      input int e_lid, input logic [3:0] e_idx, input logic [8:0] e_tag);
    vec_t v;
    v = '{rv, st, a, d, IW'(id), rsp, rtag, rdat, e_rdy, e_cmd, e_addr, e_pd,
          e_st, IW'(e_sid), e_ld, e_ldat, IW'(e_lid), e_idx, e_tag};
    tbl.push_back(v);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) push(0,0,0,0,0, 0,0,0, 1,0,0,0, 0,0,0,0,0,0,0);
  endtask

  initial begin
    int next_tag;
    foreach (busy[k]) busy[k] = 1'b0;
    acnt = 0; e_st = 0; e_ld = 0;
    clear_in();
    reset = 1;
    repeat (2) @(posedge clock);
    #1;
    reset = 0;

    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_command", bus.proc2mem_command, 0);
    chk("rst_mem_addr", bus.proc2mem_addr, 0);
    chk("rst_mem_data", bus.proc2mem_data, 0);
    chk("rst_wr_mem_en", bus.wr_mem_en, 0);
    chk("rst_wr_mem_idx", bus.wr_mem_idx, 0);
    chk("rst_wr_mem_tag", bus.wr_mem_tag, 0);
    chk("rst_wr_mem_data", bus.wr_mem_data, 0);
    chk("rst_ld_done_valid", bus.ld_done_valid, 0);
    chk("rst_ld_done_id", bus.ld_done_id, 0);
    chk("rst_ld_done_data", bus.ld_done_data, 0);
    chk("rst_st_done_valid", bus.st_done_valid, 0);
    chk("rst_st_done_id", bus.st_done_id, 0);

    // Single load 0x1238, response 3, tag 3 returned ten cycles later.
    push(1,0,64'h1238,0,7,  0,0,0,             1,0,0,0,             0,0,0,0,0,0,0);
    push(0,0,0,0,0,         3,0,0,             1,1,64'h1238,0,      0,0,0,0,0,0,0);
    idle(9);
    push(0,0,0,0,0,         0,3,64'hDEAD,      1,0,0,0,             0,0,0,0,0,0,0);
    push(0,0,0,0,0,         0,0,0,             1,0,0,0,             0,0,1,64'hDEAD,7,4'd7,9'h024);
    idle(1);
    // Rejected three times then accepted with tag 5; then A/B loads returned out of order.
    push(1,0,64'h2000,0,3,  0,0,0,             1,0,0,0,             0,0,0,0,0,0,0);
    push(0,0,0,0,0,         0,0,0,             1,1,64'h2000,0,      0,0,0,0,0,0,0);
    push(0,0,0,0,0,         0,0,0,             1,1,64'h2000,0,      0,0,0,0,0,0,0);
    push(0,0,0,0,0,         0,0,0,             1,1,64'h2000,0,      0,0,0,0,0,0,0);
    push(0,0,0,0,0,         5,0,0,             1,1,64'h2000,0,      0,0,0,0,0,0,0);
    push(1,0,64'h300F,0,10, 0,0,0,             1,0,0,0,             0,0,0,0,0,0,0);
    push(1,0,64'h4010,0,11, 1,0,0,             1,1,64'h3008,0,      0,0,0,0,0,0,0);
    push(0,0,0,0,0,         2,0,0,             1,1,64'h4010,0,      0,0,0,0,0,0,0);
    push(0,0,0,0,0,         0,2,64'hBBBB,      1,0,0,0,             0,0,0,0,0,0,0);
    push(0,0,0,0,0,         0,1,64'hAAAA,      1,0,0,0,             0,0,1,64'hBBBB,11,4'd2,9'h080);
    push(0,0,0,0,0,         0,5,64'h5555,      1,0,0,0,             0,0,1,64'hAAAA,10,4'd1,9'h060);
    push(0,0,0,0,0,         0,0,0,             1,0,0,0,             0,0,1,64'h5555,3,4'd0,9'h040);
    idle(1);
    // Store then load to the same block: STORE strictly first, store done next cycle.
    push(1,1,64'h100,64'h55,20, 0,0,0,         1,0,0,0,             0,0,0,0,0,0,0);
    push(1,0,64'h100,0,21,  6,0,0,             1,2,64'h100,64'h55,  0,0,0,0,0,0,0);
    push(0,0,0,0,0,         7,0,0,             1,1,64'h100,0,       1,20,0,0,0,0,0);
    push(0,0,0,0,0,         0,7,64'h77,        1,0,0,0,             0,0,0,0,0,0,0);
    push(0,0,0,0,0,         0,0,0,             1,0,0,0,             0,0,1,64'h77,21,4'd0,9'h002);
    idle(1);

    foreach (tbl[i]) begin
      bus.req_valid = tbl[i].rv; bus.req_is_store = tbl[i].st; bus.req_addr = tbl[i].a;
      bus.req_data = tbl[i].d; bus.req_id = tbl[i].id; bus.mem2proc_response = tbl[i].rsp;
      bus.mem2proc_tag = tbl[i].rtag; bus.mem2proc_data = tbl[i].rdat;
      chk($sformatf("v%0d_ready", i), bus.req_ready, tbl[i].e_rdy);
      chk($sformatf("v%0d_command", i), bus.proc2mem_command, tbl[i].e_cmd);
      chk($sformatf("v%0d_mem_addr", i), bus.proc2mem_addr, tbl[i].e_addr);
      if (tbl[i].e_cmd == 2'd2) chk($sformatf("v%0d_mem_data", i), bus.proc2mem_data, tbl[i].e_pd);
      chk($sformatf("v%0d_st_done", i), bus.st_done_valid, tbl[i].e_st);
      if (tbl[i].e_st) chk($sformatf("v%0d_st_id", i), bus.st_done_id, tbl[i].e_sid);
      chk($sformatf("v%0d_ld_done", i), bus.ld_done_valid, tbl[i].e_ld);
      chk($sformatf("v%0d_wr_mem_en", i), bus.wr_mem_en, tbl[i].e_ld);
      if (tbl[i].e_ld) begin
        chk($sformatf("v%0d_ld_data", i), bus.ld_done_data, tbl[i].e_ldat);
        chk($sformatf("v%0d_ld_id", i), bus.ld_done_id, tbl[i].e_lid);
        chk($sformatf("v%0d_idx", i), bus.wr_mem_idx, tbl[i].e_idx);
        chk($sformatf("v%0d_tag", i), bus.wr_mem_tag, tbl[i].e_tag);
      end
      cycle();
    end

    // Fill all entries with loads that never return, then free entry 0.
    do_reset();
    next_tag = 1;
    for (int i = 0; i < 8; i++) begin
      bus.req_valid = (i < 4);
      bus.req_addr  = 64'(i + 1) << 12;
      bus.req_id    = IW'(i);
      bus.mem2proc_response = 0;
      if (bus.proc2mem_command != 2'd0) begin
        bus.mem2proc_response = 4'(next_tag);
        next_tag++;
      end
      cycle();
    end
    clear_in();
    chk("full_ready", bus.req_ready, 0);
    bus.req_valid = 1; bus.req_addr = 64'h8000; bus.req_id = 9;
    cycle();
    clear_in();
    chk("full_still_blocked", bus.req_ready, 0);
    bus.mem2proc_tag = 4'd1; bus.mem2proc_data = 64'h11;
    cycle();
    clear_in();
    chk("ready_after_free", bus.req_ready, 1);
    bus.req_valid = 1; bus.req_addr = 64'h9000; bus.req_id = 30;
    cycle();
    clear_in();
    chk("refill_entry0_cmd", bus.proc2mem_command, 1);
    chk("refill_entry0_addr", bus.proc2mem_addr, 64'h9000);

    // Reset with loads in WAIT_DATA; their tags must then produce nothing.
    reset = 1;
    cycle();
    reset = 0;
    for (int t = 2; t <= 3; t++) begin
      bus.mem2proc_tag = 4'(t); bus.mem2proc_data = 64'hBAD0 + 64'(t);
      cycle();
      chk($sformatf("rst_tag%0d_no_fill", t), bus.wr_mem_en, 0);
      chk($sformatf("rst_tag%0d_no_done", t), bus.ld_done_valid, 0);
      chk($sformatf("rst_tag%0d_ready", t), bus.req_ready, 1);
    end
    clear_in();

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      int r, base, t;
      bus.req_valid    = 1'($urandom_range(0, 1));
      bus.req_is_store = ($urandom_range(0, 2) == 0);
      bus.req_addr     = {$urandom, $urandom};
      bus.req_data     = {$urandom, $urandom};
      bus.req_id       = IW'($urandom);
      r = $urandom_range(0, 9);
      bus.mem2proc_tag = 4'd0;
      if (r < 4 && wd.size() > 0) bus.mem2proc_tag = wd[$urandom_range(0, wd.size() - 1)].tag;
      else if (r == 4) bus.mem2proc_tag = 4'($urandom_range(0, 15));
      bus.mem2proc_data = {$urandom, $urandom};
      bus.mem2proc_response = 4'd0;
      if (bus.proc2mem_command != 2'd0 && $urandom_range(0, 9) < 6) begin
        base = $urandom_range(1, 15);
        for (int k = 0; k < 15; k++) begin
          t = ((base - 1 + k) % 15) + 1;
          if (bus.mem2proc_response == 4'd0 && !tag_live(t) && t != int'(bus.mem2proc_tag))
            bus.mem2proc_response = 4'(t);
        end
      end
      reset = ($urandom_range(0, 299) == 0);
      cycle();
    end
    reset = 0;
    clear_in();
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
